// File: rtl/fetch_npc_gen_pkg.sv
// Shared CPU front-end types: virtual addresses, flush bundle, predictor
// result record, next-PC generator states and fixed boot/exception vectors.
package fetch_npc_gen_pkg;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb;
  } pipeline_flush_t;

  typedef struct packed {
    logic  valid;
    logic  br_op;
    logic  br_taken;
    virt_t target;
  } predict_result_t;

  typedef enum logic [1:0] {
    NPC_RUN        = 2'd0,
    NPC_WAIT_DS    = 2'd1,
    NPC_CORRECT    = 2'd2,
    NPC_HOLD_FLUSH = 2'd3
  } npc_state_t;

  localparam virt_t CPU_RESET_PC = 32'hBFC0_0000;
  localparam virt_t CPU_EX_ENTRY = 32'hBFC0_0380;

  // Instruction addresses are word aligned; drop the byte offset.
  function automatic virt_t word_align(input virt_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_npc_gen.sv
// Fetch-stage next-PC generator. Owns the fetch PC, drives the I-cache
// request handshake, applies flushes, predictor corrections and taken
// predictions (after the MIPS delay slot has been fetched).
module fetch_npc_gen
  import fetch_npc_gen_pkg::*;
#(
  parameter virt_t RESET_PC = CPU_RESET_PC,
  parameter virt_t EX_ENTRY = CPU_EX_ENTRY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_ex,
  input  logic        flush_eret,
  input  logic        flush_tlb,
  input  logic [31:0] epc,
  input  logic [31:0] refetch_pc,
  input  logic [31:0] ds_pc,
  input  logic        pred_valid,
  input  logic        pred_br_taken,
  input  logic [31:0] pred_target,
  input  logic        is_correction,
  input  logic [31:0] correct_target,
  output logic        correct_finish,
  input  logic        fs_allowin,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok
);

  npc_state_t      state_q, state_d;
  virt_t           pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  virt_t           pend_target_q, pend_target_d;
  virt_t           hold_target_q, hold_target_d;
  // Set once pc holds correct_target, i.e. the next request is the correction fetch.
  logic            corr_armed_q, corr_armed_d;

  pipeline_flush_t flush;
  logic            flush_any;
  virt_t           flush_target;
  logic            acc;
  logic            can_load;
  logic            pred_taken;

  assign flush      = '{ex: flush_ex, eret: flush_eret, tlb: flush_tlb};
  assign flush_any  = flush.ex | flush.eret | flush.tlb;
  // Exception entry outranks eret, which outranks a TLB refetch.
  assign flush_target = flush.ex   ? EX_ENTRY :
                        flush.eret ? epc      : refetch_pc;

  assign inst_req   = !reset && fs_allowin && (state_q != NPC_HOLD_FLUSH);
  assign inst_addr  = pc_q;
  assign acc        = inst_req && inst_addr_ok;
  // pc may only move when no handshake is in progress or the current one completes.
  assign can_load   = acc || !inst_req;
  assign pred_taken = pred_valid && pred_br_taken;

  assign correct_finish = acc && !flush_any && (state_q == NPC_CORRECT) && corr_armed_q;

  // Next-state / next-PC selection: flush > correction > delay-slot redirect > pc+4.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    hold_target_d = hold_target_q;
    corr_armed_d  = corr_armed_q;

    if (flush_any) begin
      pend_valid_d = 1'b0;
      corr_armed_d = 1'b0;
      if (can_load) begin
        pc_d    = word_align(flush_target);
        state_d = NPC_RUN;
      end else begin
        // Request already on the bus: let it drain, redirect afterwards.
        hold_target_d = word_align(flush_target);
        state_d       = NPC_HOLD_FLUSH;
      end
    end else begin
      case (state_q)
        NPC_HOLD_FLUSH: begin
          pc_d    = hold_target_q;
          state_d = NPC_RUN;
        end

        NPC_CORRECT: begin
          if (!corr_armed_q) begin
            // An older request may still be in flight; load the target once it is gone.
            if (can_load) begin
              pc_d         = word_align(correct_target);
              corr_armed_d = 1'b1;
            end
          end else if (acc) begin
            pc_d         = word_align(correct_target + 32'd4);
            corr_armed_d = 1'b0;
            state_d      = NPC_RUN;
          end
        end

        NPC_RUN, NPC_WAIT_DS: begin
          if (is_correction) begin
            pend_valid_d = 1'b0;
            state_d      = NPC_CORRECT;
            if (can_load) begin
              pc_d         = word_align(correct_target);
              corr_armed_d = 1'b1;
            end else begin
              corr_armed_d = 1'b0;
            end
          end else if (state_q == NPC_WAIT_DS) begin
            if (acc) begin
              pc_d         = pend_valid_q ? pend_target_q : pc_q + 32'd4;
              pend_valid_d = 1'b0;
              state_d      = NPC_RUN;
            end
          end else if (pred_taken && (pc_q == ds_pc + 32'd4)) begin
            // pc is the delay slot: redirect only once it is accepted.
            if (acc) begin
              pc_d = word_align(pred_target);
            end else begin
              pend_target_d = word_align(pred_target);
              pend_valid_d  = 1'b1;
              state_d       = NPC_WAIT_DS;
            end
          end else if (pred_taken && (pc_q == ds_pc + 32'd8)) begin
            // Delay slot already fetched: redirect at the next opportunity.
            if (can_load) begin
              pc_d = word_align(pred_target);
            end else begin
              pend_target_d = word_align(pred_target);
              pend_valid_d  = 1'b1;
              state_d       = NPC_WAIT_DS;
            end
          end else if (acc) begin
            pc_d = pc_q + 32'd4;
          end
        end

        default: state_d = NPC_RUN;
      endcase
    end
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NPC_RUN;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      hold_target_q <= '0;
      corr_armed_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      hold_target_q <= hold_target_d;
      corr_armed_q  <= corr_armed_d;
    end
  end

endmodule

// File: tb/tb_fetch_npc_gen.sv
// Bench for fetch_npc_gen: per-cycle stimulus records with expected request,
// address and correct_finish, queued at drive time and checked mid-cycle.
module tb_fetch_npc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_ex, flush_eret, flush_tlb;
  logic [31:0] epc, refetch_pc, ds_pc;
  logic        pred_valid, pred_br_taken;
  logic [31:0] pred_target;
  logic        is_correction;
  logic [31:0] correct_target;
  logic        correct_finish;
  logic        fs_allowin;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  always #5 clk = ~clk;

  fetch_npc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .flush_ex       (flush_ex),
    .flush_eret     (flush_eret),
    .flush_tlb      (flush_tlb),
    .epc            (epc),
    .refetch_pc     (refetch_pc),
    .ds_pc          (ds_pc),
    .pred_valid     (pred_valid),
    .pred_br_taken  (pred_br_taken),
    .pred_target    (pred_target),
    .is_correction  (is_correction),
    .correct_target (correct_target),
    .correct_finish (correct_finish),
    .fs_allowin     (fs_allowin),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok)
  );

  typedef struct {
    logic        rst;
    logic        ok;
    logic        allow;
    logic        pv;
    logic        tk;
    logic [31:0] ptgt;
    logic [31:0] ds;
    logic        corr;
    logic [31:0] ctgt;
    logic [1:0]  fl;     // 0 none, 1 ex, 2 eret, 3 tlb
    logic [31:0] ftgt;   // epc / refetch_pc
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fin;
  } vec_t;

  typedef struct {
    int          idx;
    logic        req;
    logic [31:0] addr;
    logic        fin;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic vec_t mk(input logic rst, input logic ok, input logic allow,
                              input logic pv, input logic tk, input logic [31:0] ptgt,
                              input logic [31:0] ds, input logic corr, input logic [31:0] ctgt,
                              input logic [1:0] fl, input logic [31:0] ftgt,
                              input logic e_req, input logic [31:0] e_addr, input logic e_fin);
    vec_t v;
    v.rst = rst; v.ok = ok; v.allow = allow; v.pv = pv; v.tk = tk; v.ptgt = ptgt;
    v.ds = ds; v.corr = corr; v.ctgt = ctgt; v.fl = fl; v.ftgt = ftgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fin = e_fin;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    reset          = v.rst;
    inst_addr_ok   = v.ok;
    fs_allowin     = v.allow;
    pred_valid     = v.pv;
    pred_br_taken  = v.tk;
    pred_target    = v.ptgt;
    ds_pc          = v.ds;
    is_correction  = v.corr;
    correct_target = v.ctgt;
    flush_ex       = (v.fl == 2'd1);
    flush_eret     = (v.fl == 2'd2);
    flush_tlb      = (v.fl == 2'd3);
    epc            = v.ftgt;
    refetch_pc     = v.ftgt;
    e.idx  = step_no;
    e.req  = v.e_req;
    e.addr = v.e_addr;
    e.fin  = v.e_fin;
    sb_q.push_back(e);
    step_no++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs against the queued expectation in the middle of each cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (inst_req !== e.req) begin
        failures++;
        $display("FAIL inst_req step %0d: got %b want %b", e.idx, inst_req, e.req);
      end
      checks++;
      if (inst_addr !== e.addr) begin
        failures++;
        $display("FAIL inst_addr step %0d: got %h want %h", e.idx, inst_addr, e.addr);
      end
      checks++;
      if (correct_finish !== e.fin) begin
        failures++;
        $display("FAIL correct_finish step %0d: got %b want %b", e.idx, correct_finish, e.fin);
      end
    end
  end

  initial begin
    // Sequential fetch after reset, with a not-taken prediction that must be ignored.
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0000,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0004,0));
    tbl.push_back(mk(0,1,1, 1,0,32'hBFC0_0900,32'hBFC0_0004,0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0008,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_000C,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0010,0));
    // Taken branch at BFC00010, delay slot BFC00014 accepted the same cycle.
    tbl.push_back(mk(0,1,1, 1,1,32'hBFC0_0100,32'hBFC0_0010,0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0014,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0100,0));
    // TLB refetch back to BFC00014, then the same branch with a stalled cache.
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd3,32'hBFC0_0014,1,32'hBFC0_0104,0));
    tbl.push_back(mk(0,0,1, 1,1,32'hBFC0_0100,32'hBFC0_0010,0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0014,0));
    tbl.push_back(mk(0,0,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0014,0));
    tbl.push_back(mk(0,0,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0014,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0014,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0100,0));
    // Correction together with a taken prediction: correction wins.
    tbl.push_back(mk(0,1,1, 1,1,32'hBFC0_0300,32'hBFC0_0100,1,32'hBFC0_0200,2'd0,32'h0,        1,32'hBFC0_0104,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'hBFC0_0200,2'd0,32'h0,        1,32'hBFC0_0200,1));
    // Refetch to BFC00040, stall with a pending prediction, then flush_ex mid-handshake.
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd3,32'hBFC0_0040,1,32'hBFC0_0204,0));
    tbl.push_back(mk(0,0,1, 1,1,32'hBFC0_0500,32'hBFC0_003C,0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0040,0));
    tbl.push_back(mk(0,0,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd1,32'h0,        1,32'hBFC0_0040,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        0,32'hBFC0_0040,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0380,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hBFC0_0384,0));
    // eret flush in the same cycle as a correction: flush wins, no finish pulse.
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        1,32'hBFC0_0200,2'd2,32'h8000_1000,1,32'hBFC0_0388,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'h8000_1000,0));
    // Refetch to the top of the address space and wrap to zero.
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd3,32'hFFFF_FFFC,1,32'h8000_1004,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'hFFFF_FFFC,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'h0000_0000,0));
    // Fetch stage not accepting: no request, PC frozen.
    tbl.push_back(mk(0,1,0, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        0,32'h0000_0004,0));
    tbl.push_back(mk(0,1,0, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        0,32'h0000_0004,0));
    // Taken prediction whose delay slot (0x0) is already fetched: redirect on this acceptance.
    tbl.push_back(mk(0,1,1, 1,1,32'h0000_0800,32'hFFFF_FFFC,0,32'h0,        2'd0,32'h0,        1,32'h0000_0004,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'h0000_0800,0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        32'h0,        0,32'h0,        2'd0,32'h0,        1,32'h0000_0804,0));

    reset = 1'b1; inst_addr_ok = 1'b1; fs_allowin = 1'b1;
    pred_valid = 1'b0; pred_br_taken = 1'b0; pred_target = '0; ds_pc = '0;
    is_correction = 1'b0; correct_target = '0;
    flush_ex = 1'b0; flush_eret = 1'b0; flush_tlb = 1'b0; epc = '0; refetch_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: no request, pc at the boot vector.
    apply(mk(1,1,1, 0,0,32'h0,32'h0,0,32'h0,2'd0,32'h0, 0,32'hBFC0_0000,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Correction arriving while an older request is stalled: that request drains first.
    apply(mk(0,0,1, 0,0,32'h0,32'h0,1,32'hBFC0_0600,2'd0,32'h0, 1,32'h0000_0808,0));
    apply(mk(0,1,1, 0,0,32'h0,32'h0,1,32'hBFC0_0600,2'd0,32'h0, 1,32'h0000_0808,0));
    apply(mk(0,1,1, 0,0,32'h0,32'h0,0,32'hBFC0_0600,2'd0,32'h0, 1,32'hBFC0_0600,1));
    apply(mk(0,1,1, 0,0,32'h0,32'h0,0,32'h0,        2'd0,32'h0, 1,32'hBFC0_0604,0));

    // Reset in the middle of a stalled handshake.
    apply(mk(0,0,1, 0,0,32'h0,32'h0,0,32'h0,2'd0,32'h0, 1,32'hBFC0_0608,0));
    apply(mk(1,0,1, 0,0,32'h0,32'h0,0,32'h0,2'd0,32'h0, 0,32'hBFC0_0608,0));
    apply(mk(1,0,1, 0,0,32'h0,32'h0,0,32'h0,2'd0,32'h0, 0,32'hBFC0_0000,0));
    apply(mk(0,1,1, 0,0,32'h0,32'h0,0,32'h0,2'd0,32'h0, 1,32'hBFC0_0000,0));
    apply(mk(0,1,1, 0,0,32'h0,32'h0,0,32'h0,2'd0,32'h0, 1,32'hBFC0_0004,0));

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
